// File: rtl/exp_sum_acc_if.sv
// Stream interface for the softmax denominator stage: exp() beats in, bf16 sum out.
// The master drives beats and out_ready; the slave is the accumulator.
interface exp_sum_acc_if #(
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_sum;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;
    logic             out_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_sat, out_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_sat, out_err
    );
endinterface

// File: rtl/exp_sum_acc.sv
// Softmax denominator: sums a packet of bf16 exp() values in unsigned fixed point
// and returns the total as bf16 with a beat count and saturation/error flags.
//
//  state    | meaning
//  ---------+-------------------------------------------------------------
//  ST_ACCUM | accepting beats, accumulating; in_last moves to ST_NORM
//  ST_NORM  | one cycle: convert acc to bf16, register result fields
//  ST_OUT   | result presented; out_ready clears state, back to ST_ACCUM
module exp_sum_acc #(
    parameter int ACC_W     = 40,
    parameter int FRAC_BITS = 16,
    parameter int CNT_W     = 16
) (
    input logic           clk,
    input logic           rst_n,
    exp_sum_acc_if.slave  bus
);
    localparam logic [1:0] ST_ACCUM = 2'd0;
    localparam logic [1:0] ST_NORM  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam int K_OFS   = FRAC_BITS - 7 - 127;
    localparam int MAX_LSH = ACC_W - 8;
    localparam int LEAD_W  = $clog2(ACC_W);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;
    logic [15:0]      out_sum_q, out_sum_d;
    logic [CNT_W-1:0] out_count_q, out_count_d;
    logic             out_sat_q, out_sat_d;
    logic             out_err_q, out_err_d;

    logic             in_sgn;
    logic [7:0]       in_exp;
    logic [7:0]       in_man;
    logic signed [10:0] shift_k;
    logic signed [10:0] neg_k;
    logic [ACC_W-1:0] conv_val;
    logic             conv_ovf;
    logic             conv_inf;
    logic             conv_err;
    logic [ACC_W:0]   acc_sum;

    logic [LEAD_W-1:0] lead_p;
    logic [7:0]        norm_exp;
    logic [6:0]        norm_man;
    logic [15:0]       norm_sum;

    // bf16 beat to fixed point: mantissa {1,m} weighted so that LSB = 2^-FRAC_BITS
    always_comb begin
        in_sgn   = bus.in_data[15];
        in_exp   = bus.in_data[14:7];
        in_man   = {1'b1, bus.in_data[6:0]};
        shift_k  = $signed({3'b000, in_exp}) + $signed(11'(K_OFS));
        neg_k    = -shift_k;
        conv_val = '0;
        conv_ovf = 1'b0;
        conv_inf = 1'b0;
        conv_err = 1'b0;
        if (in_exp == 8'h00) begin
            conv_val = '0;
        end else if (in_exp == 8'hFF) begin
            conv_inf = 1'b1;
            conv_err = in_sgn;
        end else if (in_sgn) begin
            conv_err = 1'b1;
        end else if (!shift_k[10]) begin
            if (shift_k > $signed(11'(MAX_LSH)))
                conv_ovf = 1'b1;
            else
                conv_val = ACC_W'(in_man) << shift_k[9:0];
        end else if (neg_k <= 11'sd7) begin
            conv_val = ACC_W'(in_man >> neg_k[2:0]);
        end
        acc_sum = {1'b0, acc_q} + {1'b0, conv_val};
    end

    // Fixed point back to bf16, mantissa truncated below the leading one
    always_comb begin
        lead_p = '0;
        for (int i = 0; i < ACC_W; i++) begin
            if (acc_q[i])
                lead_p = LEAD_W'(i);
        end
        norm_exp = 8'(int'(lead_p) + 127 - FRAC_BITS);
        if (lead_p >= LEAD_W'(7))
            norm_man = 7'(acc_q >> (lead_p - LEAD_W'(7)));
        else
            norm_man = 7'(acc_q << (LEAD_W'(7) - lead_p));
        if (sat_q)
            norm_sum = 16'h7F80;
        else if (acc_q == '0)
            norm_sum = 16'h0000;
        else
            norm_sum = {1'b0, norm_exp, norm_man};
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        sat_d       = sat_q;
        err_d       = err_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        case (state_q)
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    if (conv_ovf || conv_inf || acc_sum[ACC_W]) begin
                        acc_d = '1;
                        sat_d = 1'b1;
                    end else begin
                        acc_d = acc_sum[ACC_W-1:0];
                    end
                    err_d = err_q | conv_err;
                    if (&count_q)
                        sat_d = 1'b1;
                    else
                        count_d = count_q + CNT_W'(1);
                    if (bus.in_last)
                        state_d = ST_NORM;
                end
            end
            ST_NORM: begin
                out_sum_d   = norm_sum;
                out_count_d = count_q;
                out_sat_d   = sat_q;
                out_err_d   = err_q;
                state_d     = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            acc_q       <= '0;
            count_q     <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_sum   = out_sum_q;
    assign bus.out_count = out_count_q;
    assign bus.out_sat   = out_sat_q;
    assign bus.out_err   = out_err_q;
endmodule
